// File: rtl/scan_doubler.sv
`timescale 1ns/1ps
// scan_doubler: ping-pong line buffer that doubles 256-pixel NES scanlines
// horizontally and vertically into a bordered 640x480 VGA raster.

// One line bank: single address port shared by the write and read sides.
// The read is combinational; the registered output lives in the parent.
module scan_doubler_bank #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WIDTH = 12,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

module scan_doubler #(
  parameter int unsigned     SRC_W    = 256,
  parameter int unsigned     PIX_W    = 12,
  parameter int unsigned     H_OFFSET = 64,
  parameter int unsigned     ACT_W    = 640,
  parameter int unsigned     ACT_H    = 480,
  parameter logic [PIX_W-1:0] BORDER  = 12'hFFF
) (
  input  logic             CLOCK_24,
  input  logic             KEY,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [11:0]      vga_x,
  input  logic [11:0]      vga_y,
  input  logic             vga_hstart,
  output logic [PIX_W-1:0] rgb,
  output logic             underrun
);

  localparam int unsigned  AW    = $clog2(SRC_W);
  localparam logic [11:0]  X_LO  = 12'(H_OFFSET);
  localparam logic [11:0]  X_HI  = 12'(H_OFFSET + 2 * SRC_W);
  localparam logic [11:0]  X_ACT = 12'(ACT_W);
  localparam logic [11:0]  Y_ACT = 12'(ACT_H);
  localparam logic [AW-1:0] LAST = AW'(SRC_W - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wstate_t;

  wstate_t         state, state_nxt;
  logic            wbank;      // bank being filled; the other one is displayed
  logic            rd_valid;   // a complete line has been swapped in since reset
  logic [AW-1:0]   wcount;
  logic            wr_fire;
  logic            swap_evt;

  logic            in_act;
  logic            in_img;
  logic [AW-1:0]   rd_addr;

  logic            we0, we1;
  logic [AW-1:0]   addr0, addr1;
  logic [PIX_W-1:0] rdata0, rdata1, rd_data;

  assign wr_fire  = wr_valid && wr_ready;
  // Swaps only happen at the start of even active lines, so lines 2k and
  // 2k+1 both display the same bank.
  assign swap_evt = vga_hstart && (vga_y < Y_ACT) && !vga_y[0];

  // Write FSM state register.
  always_ff @(posedge CLOCK_24 or negedge KEY) begin
    if (!KEY) state <= FILL;
    else      state <= state_nxt;
  end

  // Next-state and handshake: fill until 256 pixels stored, then wait for a swap.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    case (state)
      FILL: begin
        wr_ready = 1'b1;
        if (wr_fire && (wcount == LAST)) state_nxt = FULL;
      end
      FULL: begin
        if (swap_evt) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // Write pointer; wraps to zero on the final pixel of the line.
  always_ff @(posedge CLOCK_24 or negedge KEY) begin
    if (!KEY)         wcount <= '0;
    else if (wr_fire) wcount <= (wcount == LAST) ? '0 : wcount + 1'b1;
  end

  // Bank swap on a swap event with a full line; otherwise flag a late line
  // once display has started.
  always_ff @(posedge CLOCK_24 or negedge KEY) begin
    if (!KEY) begin
      wbank    <= 1'b0;
      rd_valid <= 1'b0;
      underrun <= 1'b0;
    end else if (swap_evt) begin
      if (state == FULL) begin
        wbank    <= ~wbank;
        rd_valid <= 1'b1;
      end else if (rd_valid) begin
        underrun <= 1'b1;
      end
    end
  end

  // Read address decode from the VGA position.
  always_comb begin
    in_act  = (vga_x < X_ACT) && (vga_y < Y_ACT);
    in_img  = (vga_x >= X_LO) && (vga_x < X_HI);
    rd_addr = '0;
    if (in_img) rd_addr = AW'((vga_x - X_LO) >> 1);
  end

  // Each bank's single port is steered to the writer or the reader by wbank.
  always_comb begin
    we0     = wr_fire && !wbank;
    we1     = wr_fire &&  wbank;
    addr0   = wbank ? rd_addr : wcount;
    addr1   = wbank ? wcount  : rd_addr;
    rd_data = wbank ? rdata0  : rdata1;
  end

  scan_doubler_bank #(.DEPTH(SRC_W), .WIDTH(PIX_W)) u_bank0 (
    .clk   (CLOCK_24),
    .we    (we0),
    .addr  (addr0),
    .wdata (wr_data),
    .rdata (rdata0)
  );

  scan_doubler_bank #(.DEPTH(SRC_W), .WIDTH(PIX_W)) u_bank1 (
    .clk   (CLOCK_24),
    .we    (we1),
    .addr  (addr1),
    .wdata (wr_data),
    .rdata (rdata1)
  );

  // Output pixel register: blank, image or border.
  always_ff @(posedge CLOCK_24 or negedge KEY) begin
    if (!KEY)            rgb <= '0;
    else if (!in_act)    rgb <= '0;
    else if (in_img)     rgb <= rd_valid ? rd_data : '0;
    else                 rgb <= BORDER;
  end

endmodule

// File: tb/tb_scan_doubler.sv
`timescale 1ns/1ps
// Scoreboard bench for scan_doubler: the driver pushes expected pixels when
// it presents a VGA position; a monitor pops and compares one cycle later.
module tb_scan_doubler;

  logic        clk = 1'b0;
  logic        key;
  logic        wr_valid;
  logic        wr_ready;
  logic [11:0] wr_data;
  logic [11:0] vga_x;
  logic [11:0] vga_y;
  logic        vga_hstart;
  logic [11:0] rgb;
  logic        underrun;

  logic        probe   = 1'b0;
  logic        probe_d = 1'b0;
  logic [11:0] exp_q[$];
  string       tag_q[$];
  int          total  = 0;
  int          passed = 0;
  int          beats;

  scan_doubler dut (
    .CLOCK_24   (clk),
    .KEY        (key),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_hstart (vga_hstart),
    .rgb        (rgb),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a probe presented before edge n is answered by rgb after edge n.
  always @(posedge clk) probe_d <= probe;

  always @(negedge clk) begin
    if (probe_d) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL scoreboard_empty: got rgb %h with no expected entry", rgb);
      end else begin
        chk(tag_q.pop_front(), rgb, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic v, input logic [11:0] d, input logic [11:0] x,
                       input logic [11:0] y, input logic hs);
    @(negedge clk);
    wr_valid = v; wr_data = d; vga_x = x; vga_y = y; vga_hstart = hs; probe = 1'b0;
  endtask

  task automatic look(input logic [11:0] x, input logic [11:0] y, input logic [11:0] exp);
    drive(1'b0, 12'h000, x, y, 1'b0);
    probe = 1'b1;
    exp_q.push_back(exp);
    tag_q.push_back($sformatf("rgb_y%0d_x%0d", y, x));
  endtask

  task automatic hstart(input logic [11:0] y);
    drive(1'b0, 12'h000, 12'd0, y, 1'b1);
  endtask

  task automatic write_n(input int n, input logic [11:0] val);
    for (int i = 0; i < n; i++) drive(1'b1, val, 12'd700, 12'd500, 1'b0);
  endtask

  // Write while wr_ready is high; inc selects wr_data = start + beat index.
  task automatic fill_all(input logic inc, input int start, input logic [11:0] val,
                          output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      vga_hstart = 1'b0; probe = 1'b0; vga_x = 12'd700; vga_y = 12'd500;
      if (!wr_ready) break;
      wr_valid = 1'b1;
      wr_data  = inc ? 12'(start + n) : val;
      n++;
    end
    wr_valid = 1'b0;
  endtask

  // Probe the standard set of columns of an index-filled line.
  task automatic index_line(input logic [11:0] y);
    look(12'd64,  y, 12'h000);
    look(12'd65,  y, 12'h000);
    look(12'd66,  y, 12'h001);
    look(12'd67,  y, 12'h001);
    look(12'd300, y, 12'h076);
    look(12'd575, y, 12'h0FF);
    look(12'd63,  y, 12'hFFF);
    look(12'd576, y, 12'hFFF);
    look(12'd10,  y, 12'hFFF);
    look(12'd600, y, 12'hFFF);
    look(12'd639, y, 12'hFFF);
    look(12'd640, y, 12'h000);
    look(12'd700, y, 12'h000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    key = 1'b0; wr_valid = 1'b0; wr_data = '0; vga_x = 12'd700; vga_y = 12'd500;
    vga_hstart = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rgb",      rgb,               12'h000);
    chk("reset_wr_ready", 12'(wr_ready),     12'd1);
    chk("reset_underrun", 12'(underrun),     12'd0);
    key = 1'b1;

    // Nothing displayed before the first swap.
    look(12'd100, 12'd0, 12'h000);
    look(12'd10,  12'd0, 12'hFFF);

    // Line of index values, swap on line 0.
    fill_all(1'b1, 0, 12'h000, beats);
    chk("fill0_beats", 12'(beats), 12'd256);
    chk("fill0_full_ready", 12'(wr_ready), 12'd0);
    hstart(12'd0);
    index_line(12'd0);
    chk("ready_after_swap", 12'(wr_ready), 12'd1);

    // Odd line repeats the same bank, no underrun.
    hstart(12'd1);
    index_line(12'd1);
    chk("line1_underrun", 12'(underrun), 12'd0);
    look(12'd100, 12'd480, 12'h000);

    // Solid red line, swap on line 2.
    fill_all(1'b0, 0, 12'hF00, beats);
    chk("fill2_beats", 12'(beats), 12'd256);
    chk("fill2_full_ready", 12'(wr_ready), 12'd0);
    hstart(12'd2);
    look(12'd64,  12'd2, 12'hF00);
    look(12'd300, 12'd2, 12'hF00);
    look(12'd575, 12'd2, 12'hF00);
    look(12'd63,  12'd2, 12'hFFF);

    // Short line: no swap, line 4 repeats red, underrun latched.
    write_n(100, 12'h0AA);
    hstart(12'd4);
    look(12'd64,  12'd4, 12'hF00);
    look(12'd400, 12'd4, 12'hF00);
    chk("line4_underrun", 12'(underrun), 12'd1);

    // Final write coincides with the swap cycle of line 6.
    write_n(155, 12'h055);
    drive(1'b1, 12'h055, 12'd0, 12'd6, 1'b1);
    drive(1'b0, 12'h000, 12'd700, 12'd6, 1'b0);
    chk("line6_full_ready", 12'(wr_ready), 12'd0);
    look(12'd64, 12'd6, 12'hF00);
    hstart(12'd8);
    look(12'd64,  12'd8, 12'h0AA);
    look(12'd263, 12'd8, 12'h0AA);
    look(12'd264, 12'd8, 12'h055);
    look(12'd575, 12'd8, 12'h055);
    chk("line8_underrun_sticky", 12'(underrun), 12'd1);

    // Mid-line reset.
    drive(1'b0, 12'h000, 12'd300, 12'd9, 1'b0);
    repeat (2) drive(1'b0, 12'h000, 12'd300, 12'd9, 1'b0);
    @(negedge clk);
    key = 1'b0;
    #1;
    chk("midreset_rgb",      rgb,           12'h000);
    chk("midreset_wr_ready", 12'(wr_ready), 12'd1);
    chk("midreset_underrun", 12'(underrun), 12'd0);
    @(negedge clk);
    key = 1'b1;

    // Partial fill after reset: no swap, image stays black, no underrun.
    write_n(200, 12'h0F0);
    hstart(12'd10);
    look(12'd300, 12'd10, 12'h000);
    look(12'd10,  12'd10, 12'hFFF);
    chk("line10_underrun", 12'(underrun), 12'd0);
    fill_all(1'b0, 0, 12'h0F0, beats);
    chk("fill12_beats", 12'(beats), 12'd56);
    hstart(12'd12);
    look(12'd64,  12'd12, 12'h0F0);
    look(12'd575, 12'd12, 12'h0F0);

    repeat (3) drive(1'b0, 12'h000, 12'd700, 12'd500, 1'b0);
    chk("queue_drained", 12'(exp_q.size()), 12'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
